// File: rtl/cp0_unit.sv
// Coprocessor 0 with a configurable number of hardware interrupt lines and an optional Count/Compare timer.
// It sits beside the M stage, raises Req to flush the pipeline, and serves mfc0/mtc0 accesses.
module cp0_unit #(
  parameter int          HWINT_W   = 6,
  parameter bit          HAS_TIMER = 1'b1,
  parameter logic [31:0] PRID      = 32'h0000_7f01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A,
  input  logic [31:0]        DIn,
  input  logic               WE,
  input  logic [29:0]        PC,
  input  logic               bdIn,
  input  logic [4:0]         ExcCodeIn,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic               Req,
  output logic [31:0]        EPCout,
  output logic [31:0]        Dout,
  output logic               TimerInt
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  logic [5:0]  im_q;
  logic        exl_q, ie_q;
  logic        bd_q;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q;
  logic [31:0] epc_q;
  logic [31:0] count_q, compare_q;
  logic        pend_q;

  logic irq, exc;
  logic wr_en;

  // IP[15:10] is held in ip_q[5:0]; the timer flag shares the top line.
  always_comb begin
    ip_d = '0;
    for (int i = 0; i < HWINT_W; i++) ip_d[i] = HWInt[i];
    ip_d[5] = ip_d[5] | pend_q;
  end

  assign irq   = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign exc   = (ExcCodeIn != 5'd0) & ~exl_q;
  assign Req   = irq | exc;
  assign wr_en = WE & ~Req;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      ip_q <= ip_d;
      if (Req) begin
        exl_q     <= 1'b1;
        bd_q      <= bdIn;
        exccode_q <= irq ? 5'd0 : ExcCodeIn;
        epc_q     <= bdIn ? {PC - 30'd1, 2'b00} : {PC, 2'b00};
      end else begin
        if (EXLClr) exl_q <= 1'b0;
        if (WE && A == ADDR_SR) begin
          im_q  <= DIn[15:10];
          exl_q <= DIn[1];
          ie_q  <= DIn[0];
        end
        if (WE && A == ADDR_EPC) epc_q <= {DIn[31:2], 2'b00};
      end
    end
  end

  generate
    if (HAS_TIMER) begin : g_timer
      always_ff @(posedge clk) begin
        if (reset) begin
          count_q   <= '0;
          compare_q <= 32'hFFFF_FFFF;
          pend_q    <= 1'b0;
        end else begin
          if (wr_en && A == ADDR_COUNT) count_q <= DIn;
          else                          count_q <= count_q + 32'd1;
          // A Compare write acknowledges the timer, even on a match cycle.
          if (wr_en && A == ADDR_COMPARE) begin
            compare_q <= DIn;
            pend_q    <= 1'b0;
          end else if (count_q == compare_q) begin
            pend_q <= 1'b1;
          end
        end
      end
    end else begin : g_no_timer
      assign count_q   = '0;
      assign compare_q = '0;
      assign pend_q    = 1'b0;
    end
  endgenerate

  assign TimerInt = pend_q;
  assign EPCout   = epc_q;

  always_comb begin
    Dout = '0;
    case (A)
      ADDR_COUNT:   Dout = count_q;
      ADDR_COMPARE: Dout = compare_q;
      ADDR_SR:      Dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE:   Dout = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
      ADDR_EPC:     Dout = epc_q;
      ADDR_PRID:    Dout = PRID;
      default:      Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset state, exceptions, delay slot, interrupts, write conflict and timer.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic        WE;
  logic [29:0] PC;
  logic        bdIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCout;
  logic [31:0] Dout;
  logic        TimerInt;

  int checks = 0;
  int errors = 0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A(A), .DIn(DIn), .WE(WE), .PC(PC), .bdIn(bdIn),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr), .Req(Req),
    .EPCout(EPCout), .Dout(Dout), .TimerInt(TimerInt)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    A = a;
    #1;
    d = Dout;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    A   = a;
    DIn = d;
    WE  = 1'b1;
    tick();
    WE  = 1'b0;
  endtask

  task automatic clear_exl();
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; A = '0; DIn = '0; WE = 1'b0; PC = '0; bdIn = 1'b0;
    ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    rd(5'd15, v); check("prid", v, 32'h0000_7f01);
    rd(5'd12, v); check("sr_rst", v, 32'h0);
    rd(5'd13, v); check("cause_rst", v, 32'h0);
    rd(5'd14, v); check("epc_rst", v, 32'h0);
    rd(5'd11, v); check("compare_rst", v, 32'hFFFF_FFFF);
    rd(5'd9, v);  check("count_rst", v, 32'h0);
    check("req_rst", {31'd0, Req}, 32'd0);
    check("epcout_rst", EPCout, 32'h0);
    check("timer_rst", {31'd0, TimerInt}, 32'd0);

    // Overflow exception at 0x3000
    PC = 30'h0C00; ExcCodeIn = 5'd12; #1;
    check("exc_req", {31'd0, Req}, 32'd1);
    tick();
    ExcCodeIn = 5'd0;
    rd(5'd13, v); check("exc_cause", v, 32'h0000_0030);
    rd(5'd14, v); check("exc_epc", v, 32'h0000_3000);
    check("exc_epcout", EPCout, 32'h0000_3000);
    rd(5'd12, v); check("exc_sr", v, 32'h0000_0002);
    // EXL masks a second exception
    ExcCodeIn = 5'd4; #1;
    check("exc_masked_req", {31'd0, Req}, 32'd0);
    tick();
    ExcCodeIn = 5'd0;
    rd(5'd13, v); check("exc_masked_cause", v, 32'h0000_0030);
    clear_exl();

    // RI in a delay slot at 0x3008
    PC = 30'h0C02; bdIn = 1'b1; ExcCodeIn = 5'd10; #1;
    check("bd_req", {31'd0, Req}, 32'd1);
    tick();
    ExcCodeIn = 5'd0; bdIn = 1'b0;
    rd(5'd14, v); check("bd_epc", v, 32'h0000_3004);
    rd(5'd13, v); check("bd_cause", v, 32'h8000_0028);
    clear_exl();

    // Hardware interrupt on line 0
    wr(5'd12, 32'h0000_0401);
    rd(5'd12, v); check("sr_write", v, 32'h0000_0401);
    HWInt = 6'b000001; #1;
    check("irq_cycle_n", {31'd0, Req}, 32'd0);
    tick();
    PC = 30'h1000;
    check("irq_cycle_n1", {31'd0, Req}, 32'd1);
    tick();
    check("irq_one_cycle", {31'd0, Req}, 32'd0);
    rd(5'd13, v); check("irq_cause", v, 32'h0000_0400);
    check("irq_epc", EPCout, 32'h0000_4000);
    // eret with the line still high re-enters one cycle later
    PC = 30'h1400; EXLClr = 1'b1; #1;
    check("eret_req_same", {31'd0, Req}, 32'd0);
    tick();
    EXLClr = 1'b0;
    check("eret_req_next", {31'd0, Req}, 32'd1);
    tick();
    check("eret_epc", EPCout, 32'h0000_5000);
    HWInt = 6'b0;
    tick();
    clear_exl();
    check("irq_dropped", {31'd0, Req}, 32'd0);

    // Interrupt coinciding with an SR write: the write is lost
    HWInt = 6'b000001;
    tick();
    check("conflict_req", {31'd0, Req}, 32'd1);
    wr(5'd12, 32'h0000_0000);
    rd(5'd12, v); check("conflict_sr", v, 32'h0000_0403);
    HWInt = 6'b0;
    tick();
    clear_exl();

    // Timer: Compare=5, then Count=0 (cycle c0), then SR (cycle c1)
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    wr(5'd12, 32'h0000_8001);
    // Now in c2 with Count=1; Count reaches 5 in c6, pending visible in c7
    for (int k = 0; k < 5; k++) begin
      check("timer_quiet", {31'd0, TimerInt}, 32'd0);
      tick();
    end
    check("timer_rise", {31'd0, TimerInt}, 32'd1);
    check("timer_req_early", {31'd0, Req}, 32'd0);
    rd(5'd9, v); check("timer_count", v, 32'd6);
    tick();
    PC = 30'h2000;
    check("timer_req", {31'd0, Req}, 32'd1);
    tick();
    rd(5'd13, v); check("timer_cause", v, 32'h0000_8000);
    check("timer_epc", EPCout, 32'h0000_8000);
    wr(5'd11, 32'd1000);
    check("timer_clear", {31'd0, TimerInt}, 32'd0);

    // Count wraps to zero
    wr(5'd9, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, v); check("count_wrap", v, 32'd0);

    // Reset mid-operation overrides a pending write
    A = 5'd14; DIn = 32'h1234_5678; WE = 1'b1; reset = 1'b1;
    tick();
    WE = 1'b0; reset = 1'b0;
    rd(5'd12, v); check("rst_mid_sr", v, 32'h0);
    check("rst_mid_epc", EPCout, 32'h0);
    rd(5'd11, v); check("rst_mid_compare", v, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
